// File: rtl/usb_bulkin_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : usb_bulkin_arbiter
// Purpose  : Packet-level round-robin arbiter that merges two 8-bit AXI4-Stream
//            sources onto the single USB BULK IN endpoint stream. A burst is
//            cut after MAX_PACKET bytes so that neither source can hold the
//            endpoint for longer than one full-size USB packet.
// Revision : 1.0 - initial release
// ============================================================================
module usb_bulkin_arbiter #(
  parameter int MAX_PACKET = 512,
  parameter int CBITS      = 10
) (
  input  logic       clock,
  input  logic       areset_n,
  input  logic       enable_i,
  // source 0
  input  logic       s0_tvalid,
  output logic       s0_tready,
  input  logic       s0_tlast,
  input  logic [7:0] s0_tdata,
  // source 1
  input  logic       s1_tvalid,
  output logic       s1_tready,
  input  logic       s1_tlast,
  input  logic [7:0] s1_tdata,
  // merged stream towards the bulk IN endpoint
  output logic       m_tvalid,
  input  logic       m_tready,
  output logic       m_tlast,
  output logic [7:0] m_tdata,
  // status
  output logic [1:0] grant_o,
  output logic       split_o
);

  // The grant states are encoded one-hot so the state register doubles as
  // the registered grant vector {S1,S0}; IDLE is 2'b00 and 2'b11 is unused.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_GNT0 = 2'b01,
    ST_GNT1 = 2'b10
  } state_t;

  // Byte index of the final beat allowed in one granted burst.
  localparam logic [CBITS-1:0] c_cut_count = CBITS'(MAX_PACKET - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CBITS-1:0] r_count;
  logic [CBITS-1:0] w_count_next;
  // Source served by the most recent packet: 0 = S0, 1 = S1.
  logic             r_last_src;
  logic             w_last_src_next;

  logic             w_sel_last;
  logic             w_cut;
  logic             w_beat;

  // Datapath: combinational mux through the granted source, no added latency.
  always_comb begin
    m_tvalid   = 1'b0;
    m_tdata    = 8'h00;
    s0_tready  = 1'b0;
    s1_tready  = 1'b0;
    w_sel_last = 1'b0;
    case (r_state)
      ST_GNT0: begin
        m_tvalid   = s0_tvalid;
        m_tdata    = s0_tdata;
        w_sel_last = s0_tlast;
        s0_tready  = m_tready;
      end
      ST_GNT1: begin
        m_tvalid   = s1_tvalid;
        m_tdata    = s1_tdata;
        w_sel_last = s1_tlast;
        s1_tready  = m_tready;
      end
      default: begin
        m_tvalid   = 1'b0;
      end
    endcase

    // The burst is forced to end on its MAX_PACKET-th byte; when the source
    // itself was not at end-of-packet, the rest of its data becomes a new
    // packet after re-arbitration and split_o flags the cut beat.
    w_cut   = (r_count == c_cut_count);
    m_tlast = (r_state != ST_IDLE) && (w_sel_last || w_cut);
    w_beat  = m_tvalid && m_tready;
    split_o = w_beat && w_cut && !w_sel_last;
  end

  // Next-state logic: arbitration in IDLE, byte counting while granted.
  always_comb begin
    w_state_next    = r_state;
    w_count_next    = r_count;
    w_last_src_next = r_last_src;
    case (r_state)
      ST_IDLE: begin
        // enable_i only gates new grants; a burst in flight always finishes.
        if (enable_i) begin
          if (s0_tvalid && s1_tvalid) begin
            w_state_next = r_last_src ? ST_GNT0 : ST_GNT1;
          end else if (s0_tvalid) begin
            w_state_next = ST_GNT0;
          end else if (s1_tvalid) begin
            w_state_next = ST_GNT1;
          end
        end
      end
      ST_GNT0, ST_GNT1: begin
        // A source bubble (tvalid low) holds the grant and freezes the count.
        if (w_beat) begin
          if (m_tlast) begin
            // Returning to IDLE guarantees one idle cycle between packets.
            w_state_next    = ST_IDLE;
            w_count_next    = '0;
            w_last_src_next = (r_state == ST_GNT1);
          end else begin
            w_count_next = r_count + CBITS'(1);
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_count_next = '0;
      end
    endcase
  end

  // State, byte counter and round-robin history; reset abandons any burst.
  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_last_src <= 1'b1;   // S0 wins the first tie after reset
    end else begin
      r_state    <= w_state_next;
      r_count    <= w_count_next;
      r_last_src <= w_last_src_next;
    end
  end

  assign grant_o = r_state;

endmodule
`default_nettype wire

// File: tb/tb_usb_bulkin_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_bulkin_arbiter
// Purpose  : Self-checking bench for usb_bulkin_arbiter. Packets generated for
//            each source are pushed into per-source expected queues; a
//            negedge monitor pops and compares every beat on the merged bus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_bulkin_arbiter;

  localparam int MAX_PACKET = 512;
  localparam int CBITS      = 10;

  logic       clock = 1'b0;
  logic       areset_n;
  logic       enable_i;
  logic       s0_tvalid, s0_tready, s0_tlast;
  logic [7:0] s0_tdata;
  logic       s1_tvalid, s1_tready, s1_tlast;
  logic [7:0] s1_tdata;
  logic       m_tvalid, m_tready, m_tlast;
  logic [7:0] m_tdata;
  logic [1:0] grant_o;
  logic       split_o;

  usb_bulkin_arbiter #(.MAX_PACKET(MAX_PACKET), .CBITS(CBITS)) dut (
    .clock     (clock),
    .areset_n  (areset_n),
    .enable_i  (enable_i),
    .s0_tvalid (s0_tvalid),
    .s0_tready (s0_tready),
    .s0_tlast  (s0_tlast),
    .s0_tdata  (s0_tdata),
    .s1_tvalid (s1_tvalid),
    .s1_tready (s1_tready),
    .s1_tlast  (s1_tlast),
    .s1_tdata  (s1_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tlast   (m_tlast),
    .m_tdata   (m_tdata),
    .grant_o   (grant_o),
    .split_o   (split_o)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Bytes still to be offered by each source ({tlast,data}).
  logic [8:0] sq0[$];
  logic [8:0] sq1[$];
  // Bytes each source is expected to deliver on the merged bus, in order.
  logic [8:0] eq0[$];
  logic [8:0] eq1[$];

  int vpct   = 100;
  int rpct   = 100;
  int en_pct = 100;
  bit toggle_ready = 1'b0;
  int sent1  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_pkt(input int src, input int len);
    logic [8:0] e;
    for (int i = 0; i < len; i++) begin
      e = {(i == len - 1), 8'($urandom)};
      if (src == 0) begin sq0.push_back(e); eq0.push_back(e); end
      else          begin sq1.push_back(e); eq1.push_back(e); end
    end
  endtask

  // One clock of stimulus: retire handshaken bytes, then pick new inputs.
  task automatic tick();
    logic hs0, hs1;
    @(negedge clock);
    hs0 = s0_tvalid && s0_tready;
    hs1 = s1_tvalid && s1_tready;
    @(posedge clock);
    #1;
    if (hs0 && sq0.size() > 0) void'(sq0.pop_front());
    if (hs1 && sq1.size() > 0) begin void'(sq1.pop_front()); sent1++; end
    if (!(s0_tvalid && !hs0)) begin
      if (sq0.size() > 0 && $urandom_range(99) < vpct) begin
        s0_tvalid = 1'b1; {s0_tlast, s0_tdata} = sq0[0];
      end else begin
        s0_tvalid = 1'b0; s0_tlast = 1'($urandom); s0_tdata = 8'($urandom);
      end
    end
    if (!(s1_tvalid && !hs1)) begin
      if (sq1.size() > 0 && $urandom_range(99) < vpct) begin
        s1_tvalid = 1'b1; {s1_tlast, s1_tdata} = sq1[0];
      end else begin
        s1_tvalid = 1'b0; s1_tlast = 1'($urandom); s1_tdata = 8'($urandom);
      end
    end
    if (toggle_ready) m_tready = ~m_tready;
    else              m_tready = ($urandom_range(99) < rpct);
    enable_i = ($urandom_range(99) < en_pct);
  endtask

  task automatic run_until_empty(input int budget);
    int n = 0;
    while ((eq0.size() > 0 || eq1.size() > 0) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_remaining", 32'(eq0.size() + eq1.size()), 0);
    repeat (3) tick();
  endtask

  // Reference model: who should own the bus and where the packet boundary is.
  int mg    = -1;   // -1 idle, else granted source
  int mlast = 1;    // source served last
  int k     = 0;    // byte index within the current burst

  always @(negedge clock) begin
    logic       vld, slast, rdy_g, rdy_o;
    logic [7:0] sdat;
    logic [8:0] e;
    logic       exp_last;
    if (!areset_n) begin
      mg = -1; mlast = 1; k = 0;
    end else if (mg < 0) begin
      chk("idle_grant",   32'(grant_o),   0);
      chk("idle_mvalid",  32'(m_tvalid),  0);
      chk("idle_ready0",  32'(s0_tready), 0);
      chk("idle_ready1",  32'(s1_tready), 0);
      chk("idle_split",   32'(split_o),   0);
      if (enable_i && (s0_tvalid || s1_tvalid)) begin
        if (s0_tvalid && s1_tvalid) mg = (mlast == 1) ? 0 : 1;
        else                        mg = s0_tvalid ? 0 : 1;
      end
    end else begin
      vld   = (mg == 1) ? s1_tvalid : s0_tvalid;
      slast = (mg == 1) ? s1_tlast  : s0_tlast;
      sdat  = (mg == 1) ? s1_tdata  : s0_tdata;
      rdy_g = (mg == 1) ? s1_tready : s0_tready;
      rdy_o = (mg == 1) ? s0_tready : s1_tready;
      chk("grant", 32'(grant_o), (mg == 1) ? 32'h2 : 32'h1);
      chk("mvalid_pass", 32'(m_tvalid), 32'(vld));
      chk("tready_mirror", 32'(rdy_g), 32'(m_tready));
      chk("tready_other", 32'(rdy_o), 0);
      if (vld) begin
        chk("mdata_pass", 32'(m_tdata), 32'(sdat));
        chk("mlast_pass", 32'(m_tlast), 32'(slast || (k == MAX_PACKET - 1)));
      end
      if (vld && m_tready) begin
        if ((mg == 1 ? eq1.size() : eq0.size()) == 0) begin
          chk("unexpected_beat", 1, 0);
          e = '0;
        end else if (mg == 1) e = eq1.pop_front();
        else                  e = eq0.pop_front();
        exp_last = e[8] || (k == MAX_PACKET - 1);
        chk("beat_data",  32'(m_tdata), 32'(e[7:0]));
        chk("beat_last",  32'(m_tlast), 32'(exp_last));
        chk("beat_split", 32'(split_o), 32'((k == MAX_PACKET - 1) && !e[8]));
        if (exp_last) begin mlast = mg; mg = -1; k = 0; end
        else k++;
      end else begin
        chk("nobeat_split", 32'(split_o), 0);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    areset_n  = 1'b0;
    enable_i  = 1'b1;
    m_tready  = 1'b1;
    s0_tvalid = 1'b1; s0_tlast = 1'b0; s0_tdata = 8'h11;
    s1_tvalid = 1'b1; s1_tlast = 1'b0; s1_tdata = 8'h22;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_grant",  32'(grant_o),   0);
    chk("rst_mvalid", 32'(m_tvalid),  0);
    chk("rst_ready0", 32'(s0_tready), 0);
    chk("rst_ready1", 32'(s1_tready), 0);
    chk("rst_split",  32'(split_o),   0);
    s0_tvalid = 1'b0; s1_tvalid = 1'b0;
    areset_n = 1'b1;

    // Single S0 packet of 4 bytes.
    add_pkt(0, 4);
    run_until_empty(50);

    // Both sources continuously ready with 3-byte packets: alternation.
    for (int i = 0; i < 3; i++) begin add_pkt(0, 3); add_pkt(1, 3); end
    run_until_empty(100);

    // Long S1 packet cut at MAX_PACKET with an S0 packet queued behind it.
    add_pkt(1, 600);
    repeat (5) tick();
    add_pkt(0, 5);
    run_until_empty(1000);

    // m_tready toggling during an S0 packet.
    toggle_ready = 1'b1;
    add_pkt(0, 8);
    run_until_empty(100);
    toggle_ready = 1'b0;

    // Random traffic with bubbles, backpressure and enable gaps.
    vpct = 70; rpct = 60; en_pct = 85;
    for (int i = 0; i < 40; i++) begin
      add_pkt(int'($urandom_range(1)),
              ($urandom_range(9) == 0) ? 520 : int'($urandom_range(10, 1)));
    end
    run_until_empty(20000);
    vpct = 100; rpct = 100; en_pct = 100;

    // Reset asserted in the middle of a long S1 packet.
    sent1 = 0;
    add_pkt(1, 300);
    n = 0;
    while (sent1 < 100 && n < 2000) begin tick(); n++; end
    chk("reached_byte100", 32'(sent1 >= 100), 1);
    #1;
    areset_n = 1'b0;
    #1;
    chk("midrst_grant",  32'(grant_o),   0);
    chk("midrst_mvalid", 32'(m_tvalid),  0);
    chk("midrst_ready1", 32'(s1_tready), 0);
    sq0.delete(); sq1.delete(); eq0.delete(); eq1.delete();
    s0_tvalid = 1'b0; s1_tvalid = 1'b0;
    tick(); tick();
    areset_n = 1'b1;
    add_pkt(1, 3);
    run_until_empty(50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
